// File: rtl/uart_cmd_pkg.sv
// Shared types and frame constants for the UART command slave and its receiver.
package uart_cmd_pkg;

    localparam int BR_DEFAULT         = 434;
    localparam int DATA_BITS          = 8;
    localparam int GAP_MAX_DEFAULT    = 20000;
    localparam int RD_TIMEOUT_DEFAULT = 255;

    // Even parity: the parity bit is the XOR of the data bits, XORed with this.
    localparam logic PARITY_ODD = 1'b0;

    typedef enum logic [3:0] {
        IDLE,
        WR_WAIT,
        WR_DO,
        RD_REQ,
        RD_WAIT,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } cmd_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_cmd_slave_if.sv
// Local register bus driven by the command slave (master side) towards the register file (slave side).
interface uart_cmd_slave_if
    import uart_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = DATA_BITS
);
    logic                  reg_wr_en;
    logic                  reg_rd_en;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0] reg_wr_data;
    logic [DATA_WIDTH-1:0] reg_rd_data;
    logic                  reg_rd_vld;

    modport master (
        output reg_wr_en, reg_rd_en, reg_addr, reg_wr_data,
        input  reg_rd_data, reg_rd_vld
    );

    modport slave (
        input  reg_wr_en, reg_rd_en, reg_addr, reg_wr_data,
        output reg_rd_data, reg_rd_vld
    );
endinterface

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-FF synchroniser, start confirmation at half bit, centre sampling,
// even-parity and stop-bit checks; reports each frame as a one-cycle byte_vld or byte_err.
module uart_rx_byte
    import uart_cmd_pkg::*;
#(
    parameter int BR         = BR_DEFAULT,
    parameter int DATA_WIDTH = DATA_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  byte_vld,
    output logic                  byte_err,
    output logic                  active
);
    localparam int CW = $clog2(BR);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] HALF_LAST = CW'(BR / 2 - 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BR - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    rx_state_e             state, state_nxt;
    logic                  rx_meta, rx_sync, rx_prev;
    logic [CW-1:0]         baud_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  parity_ok;
    logic                  sample;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        sample    = 1'b0;
        unique case (state)
            RX_IDLE:   if (rx_prev && !rx_sync) state_nxt = RX_START;
            RX_START:  if (baud_cnt == HALF_LAST) begin
                           sample    = 1'b1;
                           state_nxt = rx_sync ? RX_IDLE : RX_DATA;
                       end
            RX_DATA:   if (baud_cnt == BAUD_LAST) begin
                           sample = 1'b1;
                           if (bit_cnt == BIT_LAST) state_nxt = RX_PARITY;
                       end
            RX_PARITY: if (baud_cnt == BAUD_LAST) begin
                           sample    = 1'b1;
                           state_nxt = RX_STOP;
                       end
            RX_STOP:   if (baud_cnt == BAUD_LAST) begin
                           sample    = 1'b1;
                           state_nxt = RX_IDLE;
                       end
            default:   state_nxt = RX_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            state     <= RX_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            parity_ok <= 1'b0;
            byte_vld  <= 1'b0;
            byte_err  <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            state    <= state_nxt;
            byte_vld <= 1'b0;
            byte_err <= 1'b0;
            baud_cnt <= (state == RX_IDLE || sample) ? '0 : baud_cnt + 1'b1;
            if (state != RX_DATA)
                bit_cnt <= '0;
            else if (sample)
                bit_cnt <= bit_cnt + 1'b1;
            if (sample) begin
                unique case (state)
                    RX_DATA:   shift     <= {rx_sync, shift[DATA_WIDTH-1:1]};
                    RX_PARITY: parity_ok <= (((^shift) ^ PARITY_ODD) == rx_sync);
                    RX_STOP:   if (rx_sync && parity_ok) byte_vld <= 1'b1;
                               else                      byte_err <= 1'b1;
                    default:   ;
                endcase
            end
        end
    end

    assign data   = shift;
    assign active = (state == RX_DATA) || (state == RX_PARITY) || (state == RX_STOP);

endmodule

// File: rtl/uart_cmd_slave.sv
// UART command slave: decodes {rw, addr, wdata} frames into register-bus strobes and
// serialises read data back on tx (start, 8 data bits LSB first, even parity, stop).
module uart_cmd_slave
    import uart_cmd_pkg::*;
#(
    parameter int BR         = BR_DEFAULT,
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = DATA_BITS,
    parameter int GAP_MAX    = GAP_MAX_DEFAULT,
    parameter int RD_TIMEOUT = RD_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    output logic             tx,
    uart_cmd_slave_if.master bus,
    output logic             busy,
    output logic             err
);
    localparam int CW       = $clog2(BR);
    localparam int BW       = $clog2(DATA_WIDTH);
    localparam int WAIT_MAX = (GAP_MAX > RD_TIMEOUT) ? GAP_MAX : RD_TIMEOUT;
    localparam int WW       = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BR - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic [WW-1:0] GAP_LAST  = WW'(GAP_MAX - 1);
    localparam logic [WW-1:0] RD_LAST   = WW'(RD_TIMEOUT - 1);

    cmd_state_e            state, state_nxt;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] wr_data, tx_byte, tx_byte_val, rx_data;
    logic [CW-1:0]         baud_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [WW-1:0]         wait_cnt;
    logic                  byte_vld, byte_err, rx_active, baud_last;
    logic                  addr_ld, wdata_ld, tx_byte_ld, wait_run;
    logic                  wr_en_c, rd_en_c, err_c, tx_c;

    uart_rx_byte #(.BR(BR), .DATA_WIDTH(DATA_WIDTH)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (rx_data),
        .byte_vld (byte_vld),
        .byte_err (byte_err),
        .active   (rx_active)
    );

    assign baud_last = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_nxt   = state;
        addr_ld     = 1'b0;
        wdata_ld    = 1'b0;
        tx_byte_ld  = 1'b0;
        tx_byte_val = bus.reg_rd_data;
        wait_run    = 1'b0;
        wr_en_c     = 1'b0;
        rd_en_c     = 1'b0;
        err_c       = 1'b0;
        tx_c        = 1'b1;
        unique case (state)
            IDLE: begin
                if (byte_vld) begin
                    addr_ld   = 1'b1;
                    state_nxt = rx_data[DATA_WIDTH-1] ? WR_WAIT : RD_REQ;
                end else if (byte_err) begin
                    err_c = 1'b1;
                end
            end
            WR_WAIT: begin
                // The gap timer only runs while no frame is in flight.
                wait_run = !rx_active;
                if (byte_vld) begin
                    wdata_ld  = 1'b1;
                    state_nxt = WR_DO;
                end else if (byte_err || (!rx_active && wait_cnt == GAP_LAST)) begin
                    err_c     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WR_DO: begin
                wr_en_c   = 1'b1;
                state_nxt = IDLE;
            end
            RD_REQ: begin
                rd_en_c = 1'b1;
                if (bus.reg_rd_vld) begin
                    tx_byte_ld = 1'b1;
                    state_nxt  = TX_START;
                end else begin
                    state_nxt  = RD_WAIT;
                end
            end
            RD_WAIT: begin
                wait_run = 1'b1;
                if (bus.reg_rd_vld) begin
                    tx_byte_ld = 1'b1;
                    state_nxt  = TX_START;
                end else if (wait_cnt == RD_LAST) begin
                    tx_byte_ld  = 1'b1;
                    tx_byte_val = '1;
                    err_c       = 1'b1;
                    state_nxt   = TX_START;
                end
            end
            TX_START: begin
                tx_c = 1'b0;
                if (baud_last) state_nxt = TX_DATA;
            end
            TX_DATA: begin
                tx_c = tx_byte[bit_cnt];
                if (baud_last && bit_cnt == BIT_LAST) state_nxt = TX_PARITY;
            end
            TX_PARITY: begin
                tx_c = (^tx_byte) ^ PARITY_ODD;
                if (baud_last) state_nxt = TX_STOP;
            end
            TX_STOP: if (baud_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cmd_addr <= '0;
            wr_data  <= '0;
            tx_byte  <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            if (addr_ld)    cmd_addr <= rx_data[ADDR_WIDTH-1:0];
            if (wdata_ld)   wr_data  <= rx_data;
            if (tx_byte_ld) tx_byte  <= tx_byte_val;
            wait_cnt <= wait_run ? wait_cnt + 1'b1 : '0;
            baud_cnt <= (state inside {TX_START, TX_DATA, TX_PARITY, TX_STOP} && !baud_last)
                        ? baud_cnt + 1'b1 : '0;
            if (state != TX_DATA)
                bit_cnt <= '0;
            else if (baud_last)
                bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // NOTE: strobes decode the registered state, so they are masked while rst is high to keep reset dominant.
    assign bus.reg_wr_en   = wr_en_c & ~rst;
    assign bus.reg_rd_en   = rd_en_c & ~rst;
    assign err             = err_c & ~rst;
    assign bus.reg_addr    = cmd_addr;
    assign bus.reg_wr_data = wr_data;
    assign tx              = tx_c;
    assign busy            = (state != IDLE) || rx_active;

endmodule
